// File: rtl/jpeg_rle.sv
// jpeg_rle: zigzag walk + run-length / size-category symbol generator for one
// quantised 8x8 block, feeding a Huffman coder over a valid/ready channel.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               pulse: block in output memory is complete, encode it
//   clear_pred_i          pulse: zero DC predictor (honoured only while idle)
//   busy_o, done_o        busy from accepted start; done pulses once at the end
//   mem_en_o, mem_addr_o  read port to output memory (32 words, 2 coefs/word)
//   mem_dat_i             read data, valid the cycle after mem_en_o
//   sym_valid_o/ready_i   symbol handshake
//   sym_run_o, sym_size_o, sym_amp_o, sym_dc_o, sym_eob_o, sym_last_o
//                         symbol fields (held stable while stalled)
//
// State table
//   state | meaning
//   IDLE  | waiting for start_i; clear_pred_i accepted here
//   FETCH | read word holding coefficient zigzag[zz]
//   EVAL  | classify coefficient: DC diff, zero (extend run) or non-zero AC
//   ZRL   | emitting (15,0) symbols while the pending run is >= 16
//   EMIT  | holding a DC/AC symbol until handshake
//   EOB   | holding end-of-block symbol until handshake
//   DONE  | one-cycle done pulse, back to IDLE

module jpeg_rle #(
  parameter int COEF_W = 16,
  parameter int AMP_W  = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                clear_pred_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                mem_en_o,
  output logic [4:0]          mem_addr_o,
  input  logic [2*COEF_W-1:0] mem_dat_i,
  output logic                sym_valid_o,
  input  logic                sym_ready_i,
  output logic [3:0]          sym_run_o,
  output logic [3:0]          sym_size_o,
  output logic [AMP_W-1:0]    sym_amp_o,
  output logic                sym_dc_o,
  output logic                sym_eob_o,
  output logic                sym_last_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_ZRL   = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_EOB   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // zigzag index -> raster index
  localparam logic [5:0] ZZ_ROM [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [2:0]       state_q, state_d;
  logic [5:0]       zz_q, zz_d;
  logic [5:0]       run_q, run_d;
  logic [12:0]      pred_q, pred_d;
  logic [3:0]       pend_size_q, pend_size_d;
  logic [AMP_W-1:0] pend_amp_q, pend_amp_d;
  logic             sym_valid_q, sym_valid_d;
  logic [3:0]       sym_run_q, sym_run_d;
  logic [3:0]       sym_size_q, sym_size_d;
  logic [AMP_W-1:0] sym_amp_q, sym_amp_d;
  logic             sym_dc_q, sym_dc_d;
  logic             sym_eob_q, sym_eob_d;
  logic             sym_last_q, sym_last_d;

  logic [5:0]        raster;
  logic [COEF_W-1:0] half;
  logic [12:0]       coef13;
  logic              coef_nz;
  logic [12:0]       diff;
  logic [12:0]       val;
  logic              neg;
  logic [12:0]       mag;
  logic [3:0]        val_size;
  logic [AMP_W-1:0]  amp_mask;
  logic [AMP_W-1:0]  val_amp;
  logic              hs;
  logic              zz_last;

  function automatic logic [3:0] bit_len(input logic [12:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (m[i]) r = 4'(i + 1);
    end
    return r;
  endfunction

  assign raster  = ZZ_ROM[zz_q];
  assign half    = raster[0] ? mem_dat_i[COEF_W-1:0] : mem_dat_i[2*COEF_W-1:COEF_W];
  // Quantised values fit in 13 bits, so truncation is the sign extension.
  assign coef13  = half[12:0];
  assign coef_nz = |half;
  assign diff    = coef13 - pred_q;
  assign val     = (zz_q == 6'd0) ? diff : coef13;
  assign neg     = val[12];
  assign mag     = neg ? (~val + 13'd1) : val;
  assign val_size = bit_len(mag);
  // One's-complement style amplitude for negatives: (v-1) kept to size bits.
  // For size 12 the shift wraps to 0 and the mask becomes all ones.
  assign amp_mask = (AMP_W'(1) << val_size) - AMP_W'(1);
  assign val_amp  = neg ? ((val[AMP_W-1:0] - AMP_W'(1)) & amp_mask) : val[AMP_W-1:0];

  assign hs      = sym_valid_q & sym_ready_i;
  assign zz_last = (zz_q == 6'd63);

  always_comb begin
    state_d     = state_q;
    zz_d        = zz_q;
    run_d       = run_q;
    pred_d      = pred_q;
    pend_size_d = pend_size_q;
    pend_amp_d  = pend_amp_q;
    sym_valid_d = sym_valid_q;
    sym_run_d   = sym_run_q;
    sym_size_d  = sym_size_q;
    sym_amp_d   = sym_amp_q;
    sym_dc_d    = sym_dc_q;
    sym_eob_d   = sym_eob_q;
    sym_last_d  = sym_last_q;

    case (state_q)
      S_IDLE: begin
        if (clear_pred_i) pred_d = 13'd0;
        if (start_i) begin
          state_d = S_FETCH;
          zz_d    = 6'd0;
          run_d   = 6'd0;
        end
      end

      S_FETCH: state_d = S_EVAL;

      S_EVAL: begin
        if (zz_q == 6'd0) begin
          pred_d      = coef13;
          sym_valid_d = 1'b1;
          sym_run_d   = 4'd0;
          sym_size_d  = val_size;
          sym_amp_d   = val_amp;
          sym_dc_d    = 1'b1;
          sym_eob_d   = 1'b0;
          sym_last_d  = 1'b0;
          state_d     = S_EMIT;
        end else if (!coef_nz) begin
          if (zz_last) begin
            sym_valid_d = 1'b1;
            sym_run_d   = 4'd0;
            sym_size_d  = 4'd0;
            sym_amp_d   = '0;
            sym_dc_d    = 1'b0;
            sym_eob_d   = 1'b1;
            sym_last_d  = 1'b1;
            state_d     = S_EOB;
          end else begin
            run_d   = run_q + 6'd1;
            zz_d    = zz_q + 6'd1;
            state_d = S_FETCH;
          end
        end else begin
          pend_size_d = val_size;
          pend_amp_d  = val_amp;
          sym_valid_d = 1'b1;
          sym_dc_d    = 1'b0;
          sym_eob_d   = 1'b0;
          if (run_q >= 6'd16) begin
            sym_run_d  = 4'd15;
            sym_size_d = 4'd0;
            sym_amp_d  = '0;
            sym_last_d = 1'b0;
            state_d    = S_ZRL;
          end else begin
            sym_run_d  = run_q[3:0];
            sym_size_d = val_size;
            sym_amp_d  = val_amp;
            sym_last_d = zz_last;
            state_d    = S_EMIT;
          end
        end
      end

      S_ZRL: begin
        if (hs) begin
          run_d = run_q - 6'd16;
          // Staying in ZRL keeps the same (15,0) fields valid for the next one.
          if (run_d < 6'd16) begin
            sym_run_d  = run_d[3:0];
            sym_size_d = pend_size_q;
            sym_amp_d  = pend_amp_q;
            sym_last_d = zz_last;
            state_d    = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (hs) begin
          sym_valid_d = 1'b0;
          sym_run_d   = 4'd0;
          sym_size_d  = 4'd0;
          sym_amp_d   = '0;
          sym_dc_d    = 1'b0;
          sym_eob_d   = 1'b0;
          sym_last_d  = 1'b0;
          run_d       = 6'd0;
          if (zz_last) begin
            state_d = S_DONE;
          end else begin
            zz_d    = zz_q + 6'd1;
            state_d = S_FETCH;
          end
        end
      end

      S_EOB: begin
        if (hs) begin
          sym_valid_d = 1'b0;
          sym_eob_d   = 1'b0;
          sym_last_d  = 1'b0;
          state_d     = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      zz_q        <= 6'd0;
      run_q       <= 6'd0;
      pred_q      <= 13'd0;
      pend_size_q <= 4'd0;
      pend_amp_q  <= '0;
      sym_valid_q <= 1'b0;
      sym_run_q   <= 4'd0;
      sym_size_q  <= 4'd0;
      sym_amp_q   <= '0;
      sym_dc_q    <= 1'b0;
      sym_eob_q   <= 1'b0;
      sym_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      zz_q        <= zz_d;
      run_q       <= run_d;
      pred_q      <= pred_d;
      pend_size_q <= pend_size_d;
      pend_amp_q  <= pend_amp_d;
      sym_valid_q <= sym_valid_d;
      sym_run_q   <= sym_run_d;
      sym_size_q  <= sym_size_d;
      sym_amp_q   <= sym_amp_d;
      sym_dc_q    <= sym_dc_d;
      sym_eob_q   <= sym_eob_d;
      sym_last_q  <= sym_last_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign mem_en_o    = (state_q == S_FETCH);
  assign mem_addr_o  = mem_en_o ? raster[5:1] : 5'd0;
  assign sym_valid_o = sym_valid_q;
  assign sym_run_o   = sym_run_q;
  assign sym_size_o  = sym_size_q;
  assign sym_amp_o   = sym_amp_q;
  assign sym_dc_o    = sym_dc_q;
  assign sym_eob_o   = sym_eob_q;
  assign sym_last_o  = sym_last_q;

endmodule

// File: tb/tb_jpeg_rle.sv
// tb_jpeg_rle: directed test of jpeg_rle. A small registered memory model
// serves coefficients; symbols are collected per block and compared against
// hand-computed sequences.

module tb_jpeg_rle;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        clear_pred_i;
  logic        busy_o;
  logic        done_o;
  logic        mem_en_o;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_dat_i;
  logic        sym_valid_o;
  logic        sym_ready_i;
  logic [3:0]  sym_run_o;
  logic [3:0]  sym_size_o;
  logic [11:0] sym_amp_o;
  logic        sym_dc_o;
  logic        sym_eob_o;
  logic        sym_last_o;

  jpeg_rle #(.COEF_W(16), .AMP_W(12)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .clear_pred_i (clear_pred_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem_en_o     (mem_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_dat_i    (mem_dat_i),
    .sym_valid_o  (sym_valid_o),
    .sym_ready_i  (sym_ready_i),
    .sym_run_o    (sym_run_o),
    .sym_size_o   (sym_size_o),
    .sym_amp_o    (sym_amp_o),
    .sym_dc_o     (sym_dc_o),
    .sym_eob_o    (sym_eob_o),
    .sym_last_o   (sym_last_o)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] coef [64];

  always @(posedge clk_i) begin
    if (mem_en_o) mem_dat_i <= {coef[{mem_addr_o, 1'b0}], coef[{mem_addr_o, 1'b1}]};
  end

  logic [22:0] sym_now;
  assign sym_now = {sym_run_o, sym_size_o, sym_amp_o, sym_dc_o, sym_eob_o, sym_last_o};

  int errors = 0;
  int checks = 0;
  logic [22:0] got [$];
  logic [22:0] exp_q [$];

  function automatic logic [22:0] mk(input int run, input int size, input int amp,
                                     input bit dc, input bit eob, input bit last);
    return {4'(run), 4'(size), 12'(amp), dc, eob, last};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic zero_block();
    for (int i = 0; i < 64; i++) coef[i] = 16'h0000;
  endtask

  task automatic pulse_clear();
    @(negedge clk_i);
    clear_pred_i = 1'b1;
    @(negedge clk_i);
    clear_pred_i = 1'b0;
  endtask

  // Start a block, collect every handshaken symbol into got, optionally stall
  // the symbol with index stall_idx for stall_len cycles.
  task automatic run_block(input string name, input int stall_idx, input int stall_len);
    int cyc;
    int last_hs;
    int done_cyc;
    int stall_ctr;
    logic [22:0] snap;
    got.delete();
    last_hs   = -10;
    done_cyc  = -1;
    stall_ctr = 0;
    snap      = '0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy_o), 32'd1);
    check({name, "_first_read"}, {26'd0, mem_en_o, mem_addr_o}, {26'd0, 1'b1, 5'd0});
    cyc = 0;
    while (cyc < 2000 && done_cyc < 0) begin
      if (done_o) begin
        done_cyc = cyc;
        check({name, "_busy_at_done"}, 32'(busy_o), 32'd0);
      end else if (sym_valid_o) begin
        if (got.size() == stall_idx && stall_ctr < stall_len) begin
          sym_ready_i = 1'b0;
          if (stall_ctr == 0) snap = sym_now;
          else check({name, "_stall_hold"}, 32'(sym_now), 32'(snap));
          check({name, "_stall_mem_en"}, 32'(mem_en_o), 32'd0);
          stall_ctr++;
        end else begin
          sym_ready_i = 1'b1;
          got.push_back(sym_now);
          last_hs = cyc;
        end
      end else begin
        sym_ready_i = 1'b0;
      end
      @(negedge clk_i);
      cyc++;
    end
    sym_ready_i = 1'b0;
    check({name, "_done_timing"}, 32'(done_cyc), 32'(last_hs + 1));
    check({name, "_done_one_cycle"}, 32'(done_o), 32'd0);
    check({name, "_nsym"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_sym%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic found;
    rst_i = 1'b1;
    start_i = 1'b0;
    clear_pred_i = 1'b0;
    sym_ready_i = 1'b0;
    zero_block();
    repeat (3) @(negedge clk_i);

    // reset state
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_mem", {26'd0, mem_en_o, mem_addr_o}, 32'd0);
    check("rst_valid", 32'(sym_valid_o), 32'd0);
    check("rst_sym", 32'(sym_now), 32'd0);
    rst_i = 1'b0;

    // all-zero block after clear
    pulse_clear();
    exp_q = '{mk(0, 0, 0, 1, 0, 0), mk(0, 0, 0, 0, 1, 1)};
    run_block("zero", -1, 0);

    // block A: DC=5, block B: DC=3 (diff -2)
    zero_block();
    coef[0] = 16'd5;
    exp_q = '{mk(0, 3, 5, 1, 0, 0), mk(0, 0, 0, 0, 1, 1)};
    run_block("blkA", -1, 0);
    coef[0] = 16'd3;
    exp_q = '{mk(0, 2, 1, 1, 0, 0), mk(0, 0, 0, 0, 1, 1)};
    run_block("blkB", -1, 0);

    // raster1=-1, raster16=3
    pulse_clear();
    zero_block();
    coef[1]  = 16'hFFFF;
    coef[16] = 16'd3;
    exp_q = '{mk(0, 0, 0, 1, 0, 0), mk(0, 1, 0, 0, 0, 0), mk(1, 2, 3, 0, 0, 0),
              mk(0, 0, 0, 0, 1, 1)};
    run_block("ac", -1, 0);

    // same block, second symbol stalled 5 cycles: identical sequence
    pulse_clear();
    run_block("stall", 1, 5);

    // only raster63=-4: three ZRLs then last AC, no EOB
    pulse_clear();
    zero_block();
    coef[63] = 16'hFFFC;
    exp_q = '{mk(0, 0, 0, 1, 0, 0), mk(15, 0, 0, 0, 0, 0), mk(15, 0, 0, 0, 0, 0),
              mk(15, 0, 0, 0, 0, 0), mk(14, 3, 3, 0, 0, 1)};
    run_block("zrl", -1, 0);

    // reset while in ZRL; use a non-zero DC first so the predictor matters
    pulse_clear();
    coef[0] = 16'd7;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk_i);
      if (sym_valid_o && !sym_dc_o && sym_run_o == 4'd15 && sym_size_o == 4'd0) found = 1'b1;
      else sym_ready_i = sym_valid_o;
    end
    check("zrl_reached", 32'(found), 32'd1);
    sym_ready_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_valid", 32'(sym_valid_o), 32'd0);
    check("midrst_sym", 32'(sym_now), 32'd0);
    check("midrst_mem", {26'd0, mem_en_o, mem_addr_o}, 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    check("midrst_no_done", 32'(done_o), 32'd0);

    zero_block();
    coef[0] = 16'd5;
    exp_q = '{mk(0, 3, 5, 1, 0, 0), mk(0, 0, 0, 0, 1, 1)};
    run_block("postrst", -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_rle.md
Name: jpeg_rle

Overview:
- Entropy-prep stage directly downstream of the DCT/quantiser output memory in the JPEG accelerator.
- Once a quantised 8x8 block has been written to the output memory, this block walks the 64 coefficients in zigzag order.
- It produces JPEG (run, size, amplitude) symbols with a valid/ready handshake for a following Huffman coder:
  - one DC-difference symbol;
  - AC symbols, with ZRL and EOB insertion.

Parameters:
COEF_W, 16, width of one stored quantised coefficient (two's complement)
AMP_W, 12, width of amplitude field on symbol output

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle pulse: block in output memory is complete, begin encoding
clear_pred_i  in  1  one-cycle pulse: zero DC predictor (new scan/component); ignored while busy_o
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse after last symbol handshaken
mem_en_o  out  1  read enable to output memory port
mem_addr_o  out  5  word address (32 words x 2 coefficients)
mem_dat_i  in  32  read data, valid cycle after mem_en_o; coef 2k at [31:16], 2k+1 at [15:0]
sym_valid_o  out  1  symbol valid
sym_ready_i  in  1  consumer accepts symbol when valid&ready
sym_run_o  out  4  zero run preceding coefficient (0 for DC/EOB, 15 for ZRL)
sym_size_o  out  4  JPEG size category (0..12)
sym_amp_o  out  AMP_W  amplitude bits, right-aligned, upper bits zero
sym_dc_o  out  1  symbol is DC difference
sym_eob_o  out  1  symbol is EOB
sym_last_o  out  1  final symbol of block (EOB, or AC at zigzag index 63)

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset: all outputs 0, state IDLE, DC predictor 0, run counter 0, zigzag index 0.
- Coefficient indexing:
  - Raster index n lives at word n>>1.
  - n[0]=0 selects [31:16]; n[0]=1 selects [15:0].
  - The zigzag table is an internal 64x6 ROM (standard JPEG order 0,1,8,16,9,2,3,10,...).
- FSM states: IDLE, FETCH, EVAL, ZRL, EMIT, EOB, DONE.
- IDLE:
  - start_i=1 -> FETCH, busy_o=1, zz=0, run=0.
  - start_i while busy_o is ignored.
  - clear_pred_i in IDLE zeroes the predictor; if it coincides with start_i, the clear applies first.
- FETCH: mem_en_o=1, mem_addr_o=zigzag[zz]>>1 -> EVAL. The first read is issued in the cycle after start_i.
- EVAL: select the half-word and sign-extend to 13 bits.
  - zz=0: diff = coef - pred; pred <= coef; -> EMIT with dc=1, run=0.
  - zz>0, coef=0:
    - zz<63: run++, zz++, -> FETCH.
    - zz=63: -> EOB.
  - zz>0, coef!=0:
    - run>=16 -> ZRL.
    - otherwise -> EMIT.
- Size and amplitude:
  - size = bit length of |v|; v=0 gives size 0.
  - amp = v if v>0; for v<0, amp = (v-1) masked to size bits.
  - Valid ranges: |AC| <= 1023 (size <= 10); |DC diff| <= 4095 (size <= 12).
- ZRL: emit run=15, size=0, amp=0. On handshake, run -= 16; if run>=16 stay in ZRL, else -> EMIT.
- EMIT:
  - Symbol is held on the outputs until the handshake.
  - On handshake, run=0.
  - Next state: zz=63 -> DONE (sym_last_o=1, no EOB); else zz++ and -> FETCH.
- EOB: emit run=0, size=0, eob=1, last=1. On handshake -> DONE.
- DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
- Handshake rules:
  - While sym_valid_o=1 and sym_ready_i=0, all sym_* outputs are stable and no memory read is issued.
  - sym_valid_o never drops without a handshake, except on reset.
  - sym_ready_i is ignored when valid=0.
- Reset mid-block: return to IDLE immediately, predictor 0, no done_o.
- Memory contract: the memory must not be rewritten while busy_o=1.
- Throughput: at most one coefficient per 2 cycles; a zero coefficient costs 2 cycles; each symbol costs >= 1 additional cycle.

Test Plan:
- All-zero block, after clear_pred -> DC(size0, amp0, dc=1); then EOB(run0, size0, eob=1, last=1); done_o one cycle after the EOB handshake; exactly 2 symbols.
- Block A: DC=5, rest 0; then block B: DC=3, no clear:
  - A -> DC size3 amp 3'b101.
  - B diff=-2 -> size2 amp 2'b01; each block followed by EOB.
- Raster[1]=-1, raster[16]=3 (zz3), others 0, pred 0 -> DC(0,0), (run0,size1,amp0), (run1,size2,amp 2'b11), EOB.
- Only raster[63]=-4 (zz63) -> DC(0,0), ZRL, ZRL, ZRL, (run14, size3, amp 3'b011, last=1); no EOB.
- Backpressure: hold sym_ready_i=0 for 5 cycles on the second symbol -> outputs unchanged, mem_en_o=0 throughout; sequence identical to the no-stall case.
- Assert rst_i during the ZRL state:
  - next cycle all outputs 0, busy_o=0;
  - a following start on a DC=5 block yields DC size3 amp 5 (predictor cleared).
